pool_window_buffer: RTL and testbench

- Upstream neighbour of the 2x2 max-pooling stage.
- Accepts a raster-order stream of convolution results, one pixel per valid cycle.
- Buffers one even row and assembles non-overlapping 2x2 windows, stride 2.
- Presents each window as a packed 4-element bus with a one-cycle start strobe, matching the pooling stage's ifm/start inputs.

---
 rtl/pool_window_buffer.sv | 95 +++++++++
 tb/tb_pool_window_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_buffer.sv
// Assembles non-overlapping 2x2 windows from a raster pixel stream for the max-pooling stage.
// One even row is buffered; each odd-row/odd-col pixel completes a window.
module pool_window_buffer #(
  parameter int unsigned BUF_WIDTH    = 26,
  parameter int unsigned POOLING_SIZE = 2,
  parameter int unsigned IMG_WIDTH    = 24,
  parameter int unsigned IMG_HEIGHT   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [BUF_WIDTH-1:0]   in_data,
  output logic                   start,
  output logic [BUF_WIDTH*4-1:0] ifm,
  output logic                   frame_done,
  output logic                   sof_err
);

  localparam int unsigned COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  if (POOLING_SIZE != 2) begin : g_bad_pool
    $error("pool_window_buffer supports only POOLING_SIZE = 2");
  end

  logic [COL_W-1:0]     col_q, col_d, col_eff, col_prev;
  logic [ROW_W-1:0]     row_q, row_d, row_eff;
  logic [BUF_WIDTH-1:0] left_q;
  logic [BUF_WIDTH-1:0] line_buf [IMG_WIDTH];
  logic                 start_q, frame_done_q, sof_err_q;
  logic [BUF_WIDTH*4-1:0] ifm_q;
  logic                 at_origin, window_done, last_px;

  // in_sof forces the current pixel to (0,0), overriding the counters
  always_comb begin
    col_eff     = in_sof ? '0 : col_q;
    row_eff     = in_sof ? '0 : row_q;
    col_prev    = col_eff - COL_W'(1);
    at_origin   = (col_q == '0) && (row_q == '0);
    window_done = in_valid && row_eff[0] && col_eff[0];
    last_px     = (col_eff == COL_LAST) && (row_eff == ROW_LAST);
    col_d       = col_eff + COL_W'(1);
    row_d       = row_eff;
    if (col_eff == COL_LAST) begin
      col_d = '0;
      row_d = (row_eff == ROW_LAST) ? '0 : row_eff + ROW_W'(1);
    end
  end

  // Line buffer carries no reset; even-row writes and odd-row reads never overlap
  always_ff @(posedge clk) begin
    if (in_valid && !row_eff[0]) begin
      line_buf[col_eff] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      left_q       <= '0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
      ifm_q        <= '0;
    end else begin
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      if (in_valid) begin
        col_q <= col_d;
        row_q <= row_d;
        if (in_sof && !at_origin) begin
          sof_err_q <= 1'b1;
        end
        if (row_eff[0] && !col_eff[0]) begin
          left_q <= in_data;
        end
        if (window_done) begin
          ifm_q        <= {in_data, left_q, line_buf[col_eff], line_buf[col_prev]};
          start_q      <= 1'b1;
          frame_done_q <= last_px;
        end
      end
    end
  end

  assign start      = start_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;
  assign ifm        = ifm_q;

endmodule

// File: tb/tb_pool_window_buffer.sv
// Self-checking bench for pool_window_buffer on a 4x4 image against a pixel-index frame model.
module tb_pool_window_buffer;

  localparam int BW = 26;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          start, frame_done, sof_err;
  logic [BW*4-1:0] ifm;

  pool_window_buffer #(
    .BUF_WIDTH(BW), .POOLING_SIZE(2), .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .start(start), .ifm(ifm), .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_start = 0;
  int n_fd = 0;

  // Reference model: frame stored by raster index, position as a single pixel index
  logic [BW-1:0]   pix [W*H];
  int              pos = 0;
  logic            exp_start = 1'b0, exp_fd = 1'b0, exp_err = 1'b0;
  logic [BW*4-1:0] exp_ifm = '0;

  task automatic model_pixel(input logic sof, input logic [BW-1:0] d);
    int r, c;
    if (sof) begin
      if (pos != 0) exp_err = 1'b1;
      pos = 0;
    end
    pix[pos] = d;
    r = pos / W;
    c = pos % W;
    exp_start = 1'b0;
    exp_fd = 1'b0;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      exp_ifm   = {pix[pos], pix[pos-1], pix[pos-W], pix[pos-W-1]};
      exp_start = 1'b1;
      exp_fd    = (pos == W*H-1);
    end
    pos = (pos + 1) % (W*H);
  endtask

  task automatic check_all(input string tag);
    if (start) n_start++;
    if (frame_done) n_fd++;
    checks++;
    assert (start === exp_start) else begin
      errors++; $error("FAIL %s start: got %0b want %0b", tag, start, exp_start);
    end
    checks++;
    assert (frame_done === exp_fd) else begin
      errors++; $error("FAIL %s frame_done: got %0b want %0b", tag, frame_done, exp_fd);
    end
    checks++;
    assert (sof_err === exp_err) else begin
      errors++; $error("FAIL %s sof_err: got %0b want %0b", tag, sof_err, exp_err);
    end
    checks++;
    assert (ifm === exp_ifm) else begin
      errors++; $error("FAIL %s ifm: got %h want %h", tag, ifm, exp_ifm);
    end
  endtask

  task automatic step(input logic v, input logic sof, input logic [BW-1:0] d, input string tag);
    @(negedge clk);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    if (v) model_pixel(sof, d);
    else begin
      exp_start = 1'b0;
      exp_fd = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    pos = 0;
    exp_start = 1'b0; exp_fd = 1'b0; exp_err = 1'b0; exp_ifm = '0;
    #1 check_all("reset_async");
    @(posedge clk);
    #1 check_all("reset_held");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_count(input string tag, input int got, input int want);
    checks++;
    assert (got === want) else begin
      errors++; $error("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  initial begin
    logic signed [BW-1:0] mx, e;
    logic [BW*4-1:0] signed_win;

    #1 check_all("por");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back frame 0..15
    n_start = 0; n_fd = 0;
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, BW'(i), "b2b");
    step(1'b0, 1'b0, '0, "b2b_idle");
    check_count("b2b_starts", n_start, 4);
    check_count("b2b_frame_done", n_fd, 1);

    // Signed window at top-left, remaining pixels random
    for (int i = 0; i < 16; i++) begin
      logic [BW-1:0] d;
      d = BW'($urandom);
      if (i == 0) d = -BW'(3);
      if (i == 1) d = -BW'(1);
      if (i == 4) d = -BW'(8);
      if (i == 5) d = -BW'(2);
      step(1'b1, i == 0, d, "signed");
      if (i == 5) begin
        signed_win = {26'h3FFFFFE, 26'h3FFFFF8, 26'h3FFFFFF, 26'h3FFFFFD};
        checks++;
        assert (ifm === signed_win) else begin
          errors++; $error("FAIL signed_ifm: got %h want %h", ifm, signed_win);
        end
        mx = ifm[BW-1:0];
        for (int k = 1; k < 4; k++) begin
          e = ifm[k*BW +: BW];
          if (e > mx) mx = e;
        end
        checks++;
        assert (mx === -26'sd1) else begin
          errors++; $error("FAIL signed_max: got %0d want -1", mx);
        end
      end
    end

    // Gapped input
    n_start = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, BW'(i), "gap");
      step(1'b0, 1'b0, BW'($urandom), "gap_idle");
    end
    check_count("gap_starts", n_start, 4);

    // Mid-frame in_sof
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, BW'(i), "abort_pre");
    n_start = 0;
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, BW'(100 + i), "abort_new");
    check_count("abort_starts", n_start, 4);
    checks++;
    assert (sof_err === 1'b1) else begin
      errors++; $error("FAIL abort_sof_err: got %0b want 1", sof_err);
    end

    // Reset mid-frame, then a frame with no in_sof
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, BW'(i), "rst_pre");
    do_reset();
    n_start = 0;
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, BW'(i), "rst_post");
    check_count("rst_starts", n_start, 4);

    // Two consecutive frames
    n_start = 0; n_fd = 0;
    for (int i = 0; i < 32; i++) step(1'b1, (i % 16) == 0, BW'(200 + i), "two");
    check_count("two_starts", n_start, 8);
    check_count("two_frame_done", n_fd, 2);

    // Random gaps, data and occasional stray in_sof
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, BW'($urandom), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
